// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
//  Module : kyber_pkg
//  Brief  : Shared widths, FSM state type and helpers for the shake256
//           arbitration logic.
//  Rev    : 1.0  initial release
// ============================================================================
package kyber_pkg;

    localparam int SEED_W         = 256;
    localparam int NONCE_W        = 8;
    localparam int LEN_W          = 14;
    localparam int SHAKE_OUT_BITS = 1024;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_GUARD = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5
    } arb_state_t;

    // Width of an index into a set of n requesters (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : kyber_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : rr_arbiter
//  Brief  : Combinational round-robin winner selection. The search starts at
//           the index after last_served and wraps; output is one-hot (or zero
//           when nobody requests).
//  Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import kyber_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_served,
    output logic [NUM_REQ-1:0] winner
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the requesters in rotated order and keep the first one asking
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_served) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                winner[cand] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/shake_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : shake_arbiter
//  Brief  : Shares one shake256 core between NUM_REQ requesters. Round-robin
//           arbitration, input latching at grant, one-cycle guard against a
//           stale core_done, response capture and a timeout watchdog.
//  Rev    : 1.0  initial release
// ============================================================================
module shake_arbiter
    import kyber_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int OUT_BITS = SHAKE_OUT_BITS,
    parameter int TIMEOUT  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*SEED_W-1:0] req_seed,
    input  logic [NUM_REQ*NONCE_W-1:0] req_nonce,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [OUT_BITS-1:0]       rsp_data,
    output logic                      err,
    output logic [1:0]                err_id,
    output logic                      busy,
    output logic                      core_enable,
    output logic [SEED_W-1:0]         core_in,
    output logic [NONCE_W-1:0]        core_nonce,
    output logic [LEN_W-1:0]          core_output_len,
    input  logic [OUT_BITS-1:0]       core_output,
    input  logic                      core_done
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [NUM_REQ-1:0] arb_winner;
    logic [IDX_W-1:0] arb_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] last_served;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             err_arm;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req),
        .last_served (last_served),
        .winner      (arb_winner)
    );

    // Encode the one-hot winner into an index
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_winner[i]) begin
                arb_idx = IDX_W'(i);
            end
        end
    end

    // The last WAIT cycle is the timeout cycle; done is not accepted there
    assign timeout_hit = (state == ST_WAIT) && (cnt == CNT_W'(TIMEOUT - 1));
    // err is registered, so it is armed one count early to line up with the
    // final WAIT cycle
    assign err_arm     = (state == ST_WAIT) && !core_done && (cnt == CNT_W'(TIMEOUT - 2));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|req) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = ST_START;
            ST_START: state_nxt = ST_GUARD;
            ST_GUARD: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end else if (core_done) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs: grant spans GRANT..RESP, response pulses in RESP
    always_comb begin
        busy      = (state != ST_IDLE);
        gnt       = (state != ST_IDLE) ? win_oh : '0;
        rsp_valid = (state == ST_RESP) ? win_oh : '0;
    end

    // Datapath: winner capture, core input latching, counter, response, error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_oh          <= '0;
            win_idx         <= '0;
            last_served     <= IDX_W'(NUM_REQ - 1);
            cnt             <= '0;
            core_enable     <= 1'b0;
            core_in         <= '0;
            core_nonce      <= '0;
            core_output_len <= '0;
            rsp_data        <= '0;
            err             <= 1'b0;
            err_id          <= '0;
        end else begin
            core_enable <= (state == ST_START);
            err         <= err_arm;
            if (err_arm) begin
                err_id <= 2'(win_idx);
            end
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        win_oh  <= arb_winner;
                        win_idx <= arb_idx;
                    end
                end
                ST_GRANT: begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (win_idx == IDX_W'(i)) begin
                            core_in         <= req_seed[i*SEED_W +: SEED_W];
                            core_nonce      <= req_nonce[i*NONCE_W +: NONCE_W];
                            core_output_len <= req_len[i*LEN_W +: LEN_W];
                        end
                    end
                end
                ST_START: begin
                    cnt <= '0;
                end
                ST_WAIT: begin
                    if (timeout_hit) begin
                        last_served <= win_idx;
                    end else if (core_done) begin
                        rsp_data <= core_output;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    last_served <= win_idx;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : shake_arbiter
`default_nettype wire
